// File: rtl/three_bit_alu_sequencer.sv
// three_bit_alu_sequencer
//   Sequences a shared, purely combinational 3-bit adder (half-adder LSB,
//   no carry-in) to execute ADD, SUB, MUL and PASS on 3-bit unsigned
//   operands, producing a 6-bit result plus a carry/borrow flag.
//
//   Operation timing (accept edge to first out_valid cycle):
//     PASS 1, ADD 2, SUB 3, MUL 4.
//   SUB is computed as A + (~B + 1) using two adder passes.
//   MUL is a 3-iteration shift-add over {hi, lo}.
//   The adder inputs are driven only from state and registers, and are
//   held at zero whenever no execution cycle is running.

module three_bit_alu_sequencer (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_op,
  input  logic [2:0] in_a,
  input  logic [2:0] in_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_res,
  output logic       out_flag,
  output logic [2:0] add_a,
  output logic [2:0] add_b,
  input  logic [2:0] add_s,
  input  logic       add_c
);

  // Operation encoding on in_op.
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  // Index of the last shift-add iteration for MUL.
  localparam logic [1:0] MUL_LAST = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_SUB1 = 3'd2,
    S_SUB2 = 3'd3,
    S_MUL  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t state, state_next;

  // Latched operands, captured on accept.
  logic [2:0] a_q;
  logic [2:0] b_q;

  // SUB intermediates: two's complement of B and the carry of that pass.
  logic [2:0] t_q;
  logic       c1_q;

  // MUL shift-add accumulator and iteration counter.
  logic [2:0] hi_q;
  logic [2:0] lo_q;
  logic [1:0] iter_q;

  // Result registers; out_res keeps its last value after leaving DONE.
  logic [5:0] res_q;
  logic       flag_q;

  // Handshake qualifier.
  logic accept;

  // One shift-add step: the adder sum and carry sit above the low half,
  // and the whole 7-bit quantity moves right by one.
  logic [6:0] mul_sum;
  logic [5:0] mul_next;

  assign accept   = in_valid && (state == S_IDLE);
  assign mul_sum  = {add_c, add_s, lo_q};
  assign mul_next = mul_sum[6:1];

  assign out_res  = res_q;
  assign out_flag = flag_q;

  // State register: any reset aborts the running operation immediately.
  always_ff @(posedge in_clk or posedge in_rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    if (in_rst) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic: dispatch on op at accept, then walk the exec cycles.
  always_comb begin
    // NOTE: default first so every path assigns state_next (no latch).
    state_next = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          case (in_op)
            OP_ADD:  state_next = S_ADD;
            OP_SUB:  state_next = S_SUB1;
            OP_MUL:  state_next = S_MUL;
            OP_PASS: state_next = S_DONE;
            default: state_next = S_IDLE;
          endcase
        end
      end
      S_ADD:   state_next = S_DONE;
      S_SUB1:  state_next = S_SUB2;
      S_SUB2:  state_next = S_DONE;
      S_MUL:   state_next = (iter_q == MUL_LAST) ? S_DONE : S_MUL;
      S_DONE:  state_next = out_ready ? S_IDLE : S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic: handshake flags and adder operands for the current cycle.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = 3'b000;
    add_b     = 3'b000;
    case (state)
      S_IDLE: in_ready = 1'b1;
      S_ADD: begin
        add_a = a_q;
        add_b = b_q;
      end
      S_SUB1: begin
        add_a = ~b_q;
        add_b = 3'b001;
      end
      S_SUB2: begin
        add_a = a_q;
        add_b = t_q;
      end
      S_MUL: begin
        add_a = hi_q;
        add_b = lo_q[0] ? a_q : 3'b000;
      end
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch operands on accept and sample the adder at the end of
  // each exec cycle; results are written on the transition into DONE.
  always_ff @(posedge in_clk or posedge in_rst) begin
    // NOTE: these are a handful of flops, not a memory, so all of them are
    // reset to give a fully defined state after an aborted operation.
    if (in_rst) begin
      a_q    <= 3'b000;
      b_q    <= 3'b000;
      t_q    <= 3'b000;
      c1_q   <= 1'b0;
      hi_q   <= 3'b000;
      lo_q   <= 3'b000;
      iter_q <= 2'd0;
      res_q  <= 6'd0;
      flag_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_q    <= in_a;
            b_q    <= in_b;
            hi_q   <= 3'b000;
            lo_q   <= in_b;
            iter_q <= 2'd0;
            if (in_op == OP_PASS) begin
              res_q  <= {3'b000, in_a};
              flag_q <= 1'b0;
            end
          end
        end
        S_ADD: begin
          res_q  <= {2'b00, add_c, add_s};
          flag_q <= add_c;
        end
        S_SUB1: begin
          t_q  <= add_s;
          c1_q <= add_c;
        end
        S_SUB2: begin
          // Borrow when neither pass carried out: c1 covers B == 0.
          res_q  <= {3'b000, add_s};
          flag_q <= ~(c1_q | add_c);
        end
        S_MUL: begin
          {hi_q, lo_q} <= mul_next;
          iter_q       <= iter_q + 2'd1;
          if (iter_q == MUL_LAST) begin
            res_q  <= mul_next;
            flag_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_three_bit_alu_sequencer.sv
// Self-checking bench for three_bit_alu_sequencer.
//   Models the external combinational adder, runs a table of directed
//   vectors, randomized ops against an arithmetic reference model, and
//   hand-written backpressure and mid-operation reset sequences.

module tb_three_bit_alu_sequencer;

  logic       in_clk;
  logic       in_rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [2:0] in_a;
  logic [2:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_res;
  logic       out_flag;
  logic [2:0] add_a;
  logic [2:0] add_b;
  logic [2:0] add_s;
  logic       add_c;

  int n_cmp = 0;
  int n_err = 0;

  three_bit_alu_sequencer dut (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_flag  (out_flag),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_s     (add_s),
    .add_c     (add_c)
  );

  // External adder core: plain 3-bit unsigned add, no carry-in.
  assign {add_c, add_s} = {1'b0, add_a} + {1'b0, add_b};

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  // Hard time limit in case some wait is missed.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model: result and flag straight from the arithmetic meaning.
  function automatic logic [6:0] model(input logic [1:0] op, input int a, input int b);
    int r;
    int f;
    case (op)
      2'b00:   begin r = a + b;         f = (r > 7) ? 1 : 0; end
      2'b01:   begin r = (a - b) & 7;   f = (a < b) ? 1 : 0; end
      2'b10:   begin r = a * b;         f = 0;               end
      default: begin r = a;             f = 0;               end
    endcase
    return {f[0], r[5:0]};
  endfunction

  function automatic int latency(input logic [1:0] op);
    case (op)
      2'b00:   return 2;
      2'b01:   return 3;
      2'b10:   return 4;
      default: return 1;
    endcase
  endfunction

  // Issue one op, check latency and result, hold backpressure for `hold`
  // cycles (optionally with a spurious in_valid), then release.
  task automatic run_op(input string name, input logic [1:0] op, input logic [2:0] a,
                        input logic [2:0] b, input logic [5:0] exp_res,
                        input logic exp_flag, input int exp_lat, input int hold,
                        input bit poke_valid);
    int n;
    int w;
    bit adder_quiet;
    w = 0;
    @(negedge in_clk);
    while (!in_ready && w < 20) begin
      @(negedge in_clk);
      w++;
    end
    check({name, " ready_before"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge in_clk);
    n = 0;
    adder_quiet = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge in_clk);
      if (i == 1) begin
        // Operands and op change after accept; must have no effect.
        in_valid = 1'b0;
        in_op    = 2'($urandom_range(0, 3));
        in_a     = 3'($urandom_range(0, 7));
        in_b     = 3'($urandom_range(0, 7));
      end
      if (add_a != 3'd0 || add_b != 3'd0) adder_quiet = 1'b0;
      if (out_valid) begin
        n = i;
        break;
      end
    end
    check({name, " latency"}, n, exp_lat);
    check({name, " res"}, {26'd0, out_res}, {26'd0, exp_res});
    check({name, " flag"}, {31'd0, out_flag}, {31'd0, exp_flag});
    check({name, " done_idle_adder"}, {26'd0, add_a, add_b}, 32'd0);
    if (op == 2'b11) check({name, " pass_adder_untouched"}, {31'd0, adder_quiet}, 32'd1);
    for (int h = 0; h < hold; h++) begin
      if (poke_valid) begin
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_a     = 3'd1;
        in_b     = 3'd1;
      end
      @(negedge in_clk);
      check({name, " hold"}, {23'd0, out_valid, in_ready, out_flag, out_res},
            {23'd0, 1'b1, 1'b0, exp_flag, exp_res});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge in_clk);
    out_ready = 1'b0;
    check({name, " release"}, {30'd0, out_valid, in_ready}, 32'd1);
    check({name, " res_retained"}, {26'd0, out_res}, {26'd0, exp_res});
  endtask

  typedef struct {
    logic [1:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic [5:0] res;
    logic       flag;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{2'b00, 3'd5, 3'd6, 6'd11, 1'b1, 2};
    vecs[1]  = '{2'b00, 3'd7, 3'd7, 6'd14, 1'b1, 2};
    vecs[2]  = '{2'b00, 3'd0, 3'd0, 6'd0,  1'b0, 2};
    vecs[3]  = '{2'b01, 3'd3, 3'd5, 6'd6,  1'b1, 3};
    vecs[4]  = '{2'b01, 3'd5, 3'd0, 6'd5,  1'b0, 3};
    vecs[5]  = '{2'b01, 3'd4, 3'd4, 6'd0,  1'b0, 3};
    vecs[6]  = '{2'b01, 3'd0, 3'd7, 6'd1,  1'b1, 3};
    vecs[7]  = '{2'b10, 3'd7, 3'd7, 6'd49, 1'b0, 4};
    vecs[8]  = '{2'b10, 3'd0, 3'd5, 6'd0,  1'b0, 4};
    vecs[9]  = '{2'b10, 3'd6, 3'd3, 6'd18, 1'b0, 4};
    vecs[10] = '{2'b11, 3'd4, 3'd2, 6'd4,  1'b0, 1};
    vecs[11] = '{2'b11, 3'd7, 3'd7, 6'd7,  1'b0, 1};

    in_rst    = 1'b1;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_a      = 3'd0;
    in_b      = 3'd0;
    out_ready = 1'b0;

    // Reset state, observed while reset is still held.
    repeat (2) @(negedge in_clk);
    check("reset outputs", {20'd0, out_valid, out_flag, out_res, add_a, add_b}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    in_rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].flag, vecs[i].lat, i % 3, 1'b0);
    end

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [2:0] a;
      logic [2:0] b;
      logic [6:0] m;
      op = 2'($urandom_range(0, 3));
      a  = 3'($urandom_range(0, 7));
      b  = 3'($urandom_range(0, 7));
      m  = model(op, int'(a), int'(b));
      run_op($sformatf("rand%0d op%0d a%0d b%0d", i, op, a, b), op, a, b,
             m[5:0], m[6], latency(op), int'($urandom_range(0, 2)), 1'b1);
    end

    // Backpressure: MUL 5*3 held 5 cycles with a spurious request.
    run_op("bp mul 5*3", 2'b10, 3'd5, 3'd3, 6'd15, 1'b0, 4, 5, 1'b1);
    // The spurious request must not have been queued.
    repeat (3) begin
      @(negedge in_clk);
      check("bp no queued op", {31'd0, out_valid}, 32'd0);
    end

    // Reset during MUL iteration 1.
    @(negedge in_clk);
    in_valid = 1'b1;
    in_op    = 2'b10;
    in_a     = 3'd7;
    in_b     = 3'd7;
    @(posedge in_clk);
    @(negedge in_clk);
    in_valid = 1'b0;
    @(negedge in_clk);
    check("mid-mul adder active", {29'd0, add_a}, 32'd3);
    in_rst = 1'b1;
    #1;
    check("abort outputs zero", {20'd0, out_valid, out_flag, out_res, add_a, add_b}, 32'd0);
    check("abort in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge in_clk);
    in_rst = 1'b0;
    repeat (5) begin
      @(negedge in_clk);
      check("abort no out_valid", {30'd0, out_valid, in_ready}, 32'd1);
    end
    run_op("after reset add 1+1", 2'b00, 3'd1, 3'd1, 6'd2, 1'b0, 2, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
